// File: rtl/riscv_types.sv
// Shared RISC-V M-extension types: fn3[1:0] multiply encodings and the in-flight tag
// tracked by mul_arbiter.
package riscv_types;

    localparam logic [1:0] FN3_MUL    = 2'b00;
    localparam logic [1:0] FN3_MULH   = 2'b01;
    localparam logic [1:0] FN3_MULHSU = 2'b10;
    localparam logic [1:0] FN3_MULHU  = 2'b11;

    typedef struct packed {
        logic valid;
        logic port;
    } mul_tag_t;

endpackage

// File: rtl/mul_arb_result_fifo.sv
// Per-requester result buffer: registered FIFO with first-word-fall-through output.
// Data storage has no reset; only pointers and occupancy are cleared.
module mul_arb_result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mul_arbiter.sv
// Two-port credit-based arbiter in front of a fixed-latency shared multiplier.
// Define MUL_ARBITER_FIXED_PRIORITY_EN for strict port-0 priority instead of round-robin.
module mul_arbiter
    import riscv_types::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic [1:0]  req1_op,
    output logic        mul_new_request,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [1:0]  mul_op,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_accept,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_accept,
    output logic        tag_error
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]       req_valid, elig, grant;
    logic [1:0]       rsp_valid, rsp_accept, ret, push;
    logic [CNT_W-1:0] credit_q [2];
    logic [CNT_W-1:0] credit_d [2];
    mul_tag_t         tags_q [MUL_CYCLES];
    mul_tag_t         head_tag, tail_tag;
    logic             tag_error_q, tag_error_d;
`ifndef MUL_ARBITER_FIXED_PRIORITY_EN
    logic             last_grant_q, last_grant_d;
`endif

    assign req_valid  = {req1_valid, req0_valid};
    assign rsp_valid  = {rsp1_valid, rsp0_valid};
    assign rsp_accept = {rsp1_accept, rsp0_accept};
    assign ret        = rsp_valid & rsp_accept;

    // Gating with rst_n keeps every output low while reset is held.
    assign elig[0] = rst_n && req_valid[0] && (credit_q[0] != '0);
    assign elig[1] = rst_n && req_valid[1] && (credit_q[1] != '0);

    always_comb begin
        grant = 2'b00;
`ifdef MUL_ARBITER_FIXED_PRIORITY_EN
        if (elig[0]) begin
            grant = 2'b01;
        end else if (elig[1]) begin
            grant = 2'b10;
        end
`else
        if (elig[0] && elig[1]) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
`endif
    end

`ifndef MUL_ARBITER_FIXED_PRIORITY_EN
    assign last_grant_d = (|grant) ? grant[1] : last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign req0_ready      = grant[0];
    assign req1_ready      = grant[1];
    assign mul_new_request = |grant;

    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_op = '0;
        if (grant[0]) begin
            mul_a  = req0_rs1;
            mul_b  = req0_rs2;
            mul_op = req0_op;
        end else if (grant[1]) begin
            mul_a  = req1_rs1;
            mul_b  = req1_rs2;
            mul_op = req1_op;
        end
    end

    always_comb begin
        head_tag       = '0;
        head_tag.valid = |grant;
        head_tag.port  = grant[1];
    end

    assign tail_tag    = tags_q[MUL_CYCLES-1];
    assign push[0]     = mul_done && tail_tag.valid && !tail_tag.port;
    assign push[1]     = mul_done && tail_tag.valid && tail_tag.port;
    assign tag_error_d = tag_error_q || (mul_done && !tail_tag.valid);

    // A credit is spent at issue and returned when the requester takes the result.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            credit_d[p] = credit_q[p];
            if (grant[p] && !ret[p]) begin
                credit_d[p] = credit_q[p] - CNT_W'(1);
            end else if (ret[p] && !grant[p] && (credit_q[p] != CNT_W'(FIFO_DEPTH))) begin
                credit_d[p] = credit_q[p] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_CYCLES; i++) begin
                tags_q[i] <= '0;
            end
            credit_q[0] <= CNT_W'(FIFO_DEPTH);
            credit_q[1] <= CNT_W'(FIFO_DEPTH);
            tag_error_q <= 1'b0;
        end else begin
            tags_q[0] <= head_tag;
            for (int i = 1; i < MUL_CYCLES; i++) begin
                tags_q[i] <= tags_q[i-1];
            end
            credit_q[0] <= credit_d[0];
            credit_q[1] <= credit_d[1];
            tag_error_q <= tag_error_d;
        end
    end

    assign tag_error = tag_error_q;

    mul_arb_result_fifo #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push[0]),
        .push_data_i (mul_result),
        .pop_i       (rsp0_accept),
        .valid_o     (rsp0_valid),
        .data_o      (rsp0_data)
    );

    mul_arb_result_fifo #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push[1]),
        .push_data_i (mul_result),
        .pop_i       (rsp1_accept),
        .valid_o     (rsp1_valid),
        .data_o      (rsp1_data)
    );

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a modelled 2-cycle multiplier.
module tb_mul_arbiter;
    import riscv_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        mul_new_request;
    logic [31:0] mul_a, mul_b;
    logic [1:0]  mul_op;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_accept = 1'b0, rsp1_accept = 1'b0;
    logic        tag_error;

    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    logic        model_en = 1'b0;
    logic        cap_v = 1'b0;
    logic [31:0] cap_r = '0;
    logic [1:0]  md_v = '0;
    logic [31:0] md_r [2];
    logic        inj_done = 1'b0;
    logic [31:0] inj_res = '0;

    always #5 clk = ~clk;

    mul_arbiter #(.MUL_CYCLES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_op(req1_op),
        .mul_new_request(mul_new_request), .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op),
        .mul_done(mul_done), .mul_result(mul_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_accept(rsp0_accept),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_accept(rsp1_accept),
        .tag_error(tag_error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mul_ref(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == FN3_MULH || op == FN3_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == FN3_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == FN3_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier model and scoreboard monitor, both sampling on the falling edge.
    always @(negedge clk) begin
        cap_v = 1'b0;
        if (rst_n) begin
            if (model_en && req0_valid && req0_ready) exp_q0.push_back(mul_ref(req0_op, req0_rs1, req0_rs2));
            if (model_en && req1_valid && req1_ready) exp_q1.push_back(mul_ref(req1_op, req1_rs1, req1_rs2));
            if (rsp0_valid && rsp0_accept) begin
                check_val("rsp0_pending", 32'(exp_q0.size() != 0), 1);
                if (exp_q0.size() != 0) check_val("rsp0_data_sb", rsp0_data, exp_q0.pop_front());
            end
            if (rsp1_valid && rsp1_accept) begin
                check_val("rsp1_pending", 32'(exp_q1.size() != 0), 1);
                if (exp_q1.size() != 0) check_val("rsp1_data_sb", rsp1_data, exp_q1.pop_front());
            end
            cap_v = model_en && mul_new_request;
            cap_r = mul_ref(mul_op, mul_a, mul_b);
        end
    end

    always @(posedge clk) begin
        #1;
        md_v[1] = md_v[0];
        md_r[1] = md_r[0];
        md_v[0] = cap_v;
        md_r[0] = cap_r;
    end

    assign mul_done   = md_v[1] | inj_done;
    assign mul_result = md_v[1] ? md_r[1] : inj_res;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_accept = 1'b0; rsp1_accept = 1'b0;
        req0_op = FN3_MUL; req1_op = FN3_MUL;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_en = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_accept = 1'b1; rsp1_accept = 1'b1;
        req0_rs1 = 32'hFFFF_FFFF; req1_rs1 = 32'hA5A5_A5A5;
        exp_q0.delete();
        exp_q1.delete();
        smp();
        check_val("rst_ready0", 32'(req0_ready), 0);
        check_val("rst_ready1", 32'(req1_ready), 0);
        check_val("rst_newreq", 32'(mul_new_request), 0);
        check_val("rst_mul_a", mul_a, 0);
        check_val("rst_rsp0_valid", 32'(rsp0_valid), 0);
        check_val("rst_rsp1_valid", 32'(rsp1_valid), 0);
        check_val("rst_rsp0_data", rsp0_data, 0);
        check_val("rst_tag_error", 32'(tag_error), 0);
        step();
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic count_grants(input int n, output int g0, output int g1);
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < n; i++) begin
            smp();
            if (req0_valid && req0_ready) g0++;
            if (req1_valid && req1_ready) g1++;
            step();
        end
    endtask

    task automatic drain(input int n);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_accept = 1'b1; rsp1_accept = 1'b1;
        for (int i = 0; i < n; i++) begin
            smp();
            step();
        end
        rsp0_accept = 1'b0; rsp1_accept = 1'b0;
        check_val("drain_q0", exp_q0.size(), 0);
        check_val("drain_q1", exp_q1.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g0, g1, g;
        int exp_ord [4];
        logic [31:0] exp_a;
`ifdef MUL_ARBITER_FIXED_PRIORITY_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        step();

        // Single request 6*7 through the full path, then credit return.
        do_reset();
        model_en = 1'b1;
        req0_valid = 1'b1; req0_rs1 = 32'd6; req0_rs2 = 32'd7; req0_op = FN3_MUL;
        smp();
        check_val("t1_ready0", 32'(req0_ready), 1);
        check_val("t1_newreq", 32'(mul_new_request), 1);
        check_val("t1_mul_a", mul_a, 6);
        check_val("t1_mul_b", mul_b, 7);
        check_val("t1_mul_op", 32'(mul_op), 32'(FN3_MUL));
        step();
        req0_valid = 1'b0;
        smp();
        check_val("t1_idle_mul_a", mul_a, 0);
        check_val("t1_idle_newreq", 32'(mul_new_request), 0);
        check_val("t1_rsp0_early", 32'(rsp0_valid), 0);
        step();
        smp();
        check_val("t1_rsp0_c2", 32'(rsp0_valid), 0);
        step();
        rsp0_accept = 1'b1;
        smp();
        check_val("t1_rsp0_c3", 32'(rsp0_valid), 1);
        check_val("t1_rsp0_data", rsp0_data, 42);
        step();
        rsp0_accept = 1'b0;
        smp();
        check_val("t1_rsp0_after", 32'(rsp0_valid), 0);
        step();
        model_en = 1'b0;
        req0_valid = 1'b1;
        count_grants(6, g0, g1);
        check_val("t1_credit0_back", g0, 4);

        // Both ports contending for four cycles.
        do_reset();
        model_en = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = FN3_MULH; req1_op = FN3_MULHU;
        for (int i = 0; i < 4; i++) begin
            req0_rs1 = 32'(i + 2);          req0_rs2 = 32'hFFFF_FFF0;
            req1_rs1 = 32'hF000_0000 + 32'(i); req1_rs2 = 32'h10 + 32'(i);
            smp();
            g = req0_ready ? 0 : (req1_ready ? 1 : 2);
            check_val("t2_order", g, exp_ord[i]);
            check_val("t2_one_grant", 32'(req0_ready & req1_ready), 0);
            exp_a = (exp_ord[i] == 0) ? req0_rs1 : req1_rs1;
            check_val("t2_mul_a", mul_a, exp_a);
            step();
        end
        drain(8);

        // Port 1 with accept held low runs out of credit.
        do_reset();
        model_en = 1'b1;
        req1_valid = 1'b1; req1_op = FN3_MUL;
        req1_rs1 = 32'd1000; req1_rs2 = 32'd3;
        count_grants(7, g0, g1);
        check_val("t3_grants", g1, 4);
        rsp1_accept = 1'b1;
        smp();
        check_val("t3_no_grant_on_accept", 32'(req1_ready), 0);
        check_val("t3_rsp1_full", 32'(rsp1_valid), 1);
        step();
        rsp1_accept = 1'b0;
        req1_rs1 = 32'd1234;
        count_grants(5, g0, g1);
        check_val("t3_one_more", g1, 1);
        drain(10);

        // Credit 0 with empty FIFO: accept is ignored and no grant happens.
        do_reset();
        req0_valid = 1'b1;
        count_grants(4, g0, g1);
        check_val("t4_grants", g0, 4);
        rsp0_accept = 1'b1;
        smp();
        check_val("t4_ready0", 32'(req0_ready), 0);
        check_val("t4_rsp0_valid", 32'(rsp0_valid), 0);
        step();
        rsp0_accept = 1'b0;
        count_grants(3, g0, g1);
        check_val("t4_credit_stuck", g0, 0);

        // Stray mul_done with nothing in flight.
        do_reset();
        inj_done = 1'b1; inj_res = 32'hDEAD;
        smp();
        check_val("t5_err_before", 32'(tag_error), 0);
        step();
        inj_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check_val("t5_tag_error", 32'(tag_error), 1);
            check_val("t5_rsp0_valid", 32'(rsp0_valid), 0);
            check_val("t5_rsp1_valid", 32'(rsp1_valid), 0);
            step();
        end

        // Reset while two ops are in flight; the late done must flag an error.
        do_reset();
        model_en = 1'b1;
        req0_valid = 1'b1; req0_rs1 = 32'd9; req0_rs2 = 32'd9;
        smp();
        check_val("t6_ready0", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rs1 = 32'd5; req1_rs2 = 32'd5;
        smp();
        check_val("t6_ready1", 32'(req1_ready), 1);
        step();
        do_reset();
        smp();
        step();
        smp();
        check_val("t6_late_err", 32'(tag_error), 1);
        check_val("t6_rsp0_empty", 32'(rsp0_valid), 0);
        check_val("t6_rsp1_empty", 32'(rsp1_valid), 0);
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        count_grants(8, g0, g1);
        check_val("t6_credit0", g0, 4);
        check_val("t6_credit1", g1, 4);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, which is the fixed latency of the shared multiplier from new_request to done.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, which is the per-requester result buffer depth and the initial credit count.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning). One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  (N=0,1) operation request
- reqN_ready  out  1  request accepted this cycle when also valid
- reqN_rs1, reqN_rs2  in  32  operands
- reqN_op  in  2  fn3[1:0] (MUL/MULH/MULHSU/MULHU)
- mul_new_request  out  1  issue to the shared multiplier
- mul_a, mul_b  out  32  issued operands
- mul_op  out  2  issued op
- mul_done  in  1  multiplier result valid
- mul_result  in  32  selected result word
- rspN_valid  out  1  result available for requester N
- rspN_data  out  32  result for requester N
- rspN_accept  in  1  requester N consumes the result
- tag_error  out  1  sticky; mul_done without a tracked in-flight op

Function
REQ-004 SHALL grant at most one requester per cycle; grant N requires reqN_valid and credit N > 0.
REQ-005 SHALL arbitrate round-robin: when both are eligible, grant the port not granted last; last_grant resets to 1, so port 0 wins the first contention.
REQ-006 SHALL assert reqN_ready combinationally in the grant cycle only; a request is accepted on reqN_valid & reqN_ready.
REQ-007 SHALL drive mul_new_request, mul_a, mul_b and mul_op combinationally from the granted port in the grant cycle, with zero added latency.
REQ-008 SHALL hold mul_a, mul_b and mul_op at zero when there is no grant.
REQ-009 SHALL track in-flight ops in a MUL_CYCLES-deep tag shift register of {valid, port}, shifted every cycle and loaded at the head on grant.
REQ-010 SHALL, on mul_done, push mul_result into the result FIFO of the port held at the tag tail.
REQ-011 SHALL set tag_error if mul_done arrives with the tail tag invalid, and SHALL discard the result in that case.
REQ-012 SHALL keep credit N in 0..FIFO_DEPTH: decrement on grant N, increment on rspN_valid & rspN_accept, unchanged when both occur in the same cycle.
REQ-013 SHALL guarantee that the result FIFOs never overflow, because credits cover in-flight plus buffered results.
REQ-014 SHALL assert rspN_valid when FIFO N is non-empty, with rspN_data at its head; an accept while empty SHALL be ignored.
REQ-015 SHALL keep results in order per port; results on different ports are independent.
REQ-016 SHALL make result buffering latency one cycle: push at cycle T gives rspN_valid at T+1.

Reset
REQ-017 SHALL, on rst_n low, clear all tags, FIFOs and tag_error, set credits to FIFO_DEPTH, set last_grant to 1, and drive all outputs to 0.
REQ-018 SHALL drop in-flight ops on reset mid-operation; a mul_done arriving after reset deassertion SHALL set tag_error.

Configuration
REQ-019 SHALL, when MUL_ARBITER_FIXED_PRIORITY_EN is defined, give port 0 strict priority (port 1 granted only when port 0 is not eligible), with last_grant unused; without the macro, round-robin per REQ-005 applies.

Structure
REQ-020 SHALL take the MUL/MULH/MULHSU/MULHU fn3 constants from riscv_types, and SHALL place the in-flight tag struct typedef in riscv_types.
REQ-021 SHALL instantiate sub-module mul_arb_result_fifo (parameters DATA_WIDTH and FIFO_DEPTH) once per port.

Verification
REQ-022 Bench SHALL cover: single req0 with rs1=6, rs2=7, op MUL, plus a modelled done after 2 cycles -> rsp0_data=42 at cycle 3, with credit0 returning to 4 after accept.
REQ-023 Bench SHALL cover: both ports valid for 4 cycles -> grants in order 0,1,0,1 (macro undefined), or 0,0,0,0 (macro defined).
REQ-024 Bench SHALL cover: req1 with rsp1_accept held 0 -> exactly 4 grants, then req1_ready stays 0; one accept -> exactly one more grant.
REQ-025 Bench SHALL cover: grant N and rspN accept in the same cycle at credit 0 -> credit stays 0 and no grant occurs that cycle.
REQ-026 Bench SHALL cover: mul_done with no issue outstanding -> tag_error=1 that persists and no rsp_valid.
REQ-027 Bench SHALL cover: rst_n low while 2 ops are in flight -> FIFOs empty, credits=4, and late mul_done sets tag_error.
